psram_qpi_responder: RTL and testbench
======================================

PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

Interface
REQ-001 Parameter ADDR_W, default 12: byte-address width of the internal array (2^ADDR_W bytes); legal range 10 to 24.
REQ-002 Parameter RD_WAIT, default 6: number of wait beats between the last address nibble and the first read data nibble.
REQ-003 HCLK  input  1: single clock; all state updates on the rising edge.
REQ-004 HRESETn  input  1: reset, asynchronous assert, active-low.
REQ-005 CE_n  input  1: device chip select, active-low.
REQ-006 SCLK_EN  input  1: bus beat qualifier; a beat is any HCLK edge with CE_n=0 and SCLK_EN=1.
REQ-007 SIO_i  input  4: quad data in (command, address and write data).
REQ-008 SIO_o  output  4: quad read data out.
REQ-009 SIO_oe  output  1: high while the responder drives SIO_o.
REQ-010 CMD_ERR  output  1: one-cycle pulse on receipt of an unsupported command.

Function
REQ-011 The state machine SHALL have the states IDLE, CMD, ADDR, WAIT, RDATA, WDATA and IGNORE.
REQ-012 IDLE->CMD on the first beat; the first beat captures cmd[7:4] and the next beat captures cmd[3:0].
REQ-013 Command 0xEB (quad read) or 0x02 (quad write) SHALL go to ADDR; any other command SHALL go to IGNORE and pulse CMD_ERR in the cycle after the second command nibble.
REQ-014 ADDR SHALL capture six nibbles, MSB first, into a 24-bit address; the array index is addr[ADDR_W-1:0], and upper bits are ignored.
REQ-015 Read: after the sixth address beat, go to WAIT for exactly RD_WAIT beats with SIO_oe=0, then go to RDATA.
REQ-016 RDATA SHALL drive SIO_oe=1 and alternate the high nibble then the low nibble of mem[addr]; the address increments after each low nibble.
REQ-017 SIO_o is registered: the nibble for beat n SHALL be stable from the HCLK edge of beat n-1 through beat n.
REQ-018 Write: after the sixth address beat, go to WDATA; the first beat is the high nibble and the second beat is the low nibble. The byte is written to mem[addr] on the low-nibble beat, then the address increments.
REQ-019 Sequential increment SHALL wrap modulo 2^ADDR_W (but see REQ-028).
REQ-020 CE_n=1 in any state SHALL return the FSM to IDLE on the next edge and force SIO_oe=0. A write byte with only its high nibble received SHALL be discarded and the array left unchanged.
REQ-021 A cycle with CE_n=0 and SCLK_EN=0 SHALL hold all state, counters and outputs.
REQ-022 IGNORE SHALL consume beats with no side effects until CE_n=1.
REQ-023 The array SHALL be uninitialised after reset; a read of an unwritten location is undefined and not checked.
REQ-024 Latency from the first command beat to the first read nibble on SIO_o SHALL be 8+RD_WAIT beats.

Reset
REQ-025 While HRESETn=0: state=IDLE, SIO_o=4'h0, SIO_oe=0, CMD_ERR=0, address and nibble counters cleared.
REQ-026 Reset asserted mid-burst SHALL abort the transfer; a partially received write byte SHALL NOT be committed.
REQ-027 After HRESETn deasserts, the first beat SHALL be treated as cmd[7:4] only if CE_n has been sampled high at least once since reset; otherwise the responder stays in IDLE until a CE_n high-to-low transition.

Configuration
REQ-028 Macro PSRAM_RSP_PAGEWRAP_EN defined: burst increment SHALL wrap within a 1024-byte page, so addr[9:0] increments and addr[ADDR_W-1:10] is held. Undefined: linear wrap modulo 2^ADDR_W per REQ-019.

Verification
REQ-029 Write 0x02, address 0x000010, data A5 3C -> mem[0x10]=0xA5 and mem[0x11]=0x3C; SIO_oe stays 0 throughout.
REQ-030 Read 0xEB at 0x000010 with RD_WAIT=6 -> SIO_oe rises at beat 14 and SIO_o delivers A,5,3,C on beats 14 to 17.
REQ-031 Write burst from 0x0003FF with two bytes 11 22 -> with the macro, 0x22 lands at 0x000; without it (ADDR_W=12), 0x22 lands at 0x400.
REQ-032 Command 0x9F -> CMD_ERR pulses once, the array is unchanged and SIO_oe=0 until CE_n rises.
REQ-033 CE_n deasserted after the write high nibble of byte 2 -> byte 1 is written, byte 2's location is unchanged and the FSM is in IDLE on the next edge.
REQ-034 HRESETn pulsed low during RDATA -> SIO_oe=0 immediately (asynchronously); the next full read transaction returns correct data.

Source files
------------

// File: rtl/psram_qpi_responder_if.sv
// Quad-SPI PSRAM bus bundle: host-driven select/qualifier/data-in plus
// responder-driven read data, output enable and command-error pulse.
interface psram_qpi_responder_if;
   logic       CE_n;
   logic       SCLK_EN;
   logic [3:0] SIO_i;
   logic [3:0] SIO_o;
   logic       SIO_oe;
   logic       CMD_ERR;

   modport master (
      output CE_n, SCLK_EN, SIO_i,
      input  SIO_o, SIO_oe, CMD_ERR
   );

   modport slave (
      input  CE_n, SCLK_EN, SIO_i,
      output SIO_o, SIO_oe, CMD_ERR
   );
endinterface

// File: rtl/psram_qpi_responder.sv
// QPI PSRAM responder model: quad read (0xEB) / quad write (0x02) into a 2^ADDR_W byte array.
// Define PSRAM_RSP_PAGEWRAP_EN to make bursts wrap inside a 1024-byte page.
module psram_qpi_responder #(
   parameter int ADDR_W  = 12,
   parameter int RD_WAIT = 6
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   psram_qpi_responder_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE} state_t;

   localparam int         CNT_W      = $clog2(RD_WAIT + 8);
   localparam int         WAIT_LAST  = (RD_WAIT > 0) ? RD_WAIT - 1 : 0;
   localparam logic [7:0] CMD_QREAD  = 8'hEB;
   localparam logic [7:0] CMD_QWRITE = 8'h02;

   logic [7:0] mem_q [0:(1 << ADDR_W) - 1];

   state_t             state_q, state_d;
   logic [23:0]        addr_q, addr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         cmd_hi_q, cmd_hi_d;
   logic               is_rd_q, is_rd_d;
   logic               lo_q, lo_d;
   logic [3:0]         wbuf_q, wbuf_d;
   logic [3:0]         sio_o_q, sio_o_d;
   logic               sio_oe_q, sio_oe_d;
   logic               cmd_err_q, cmd_err_d;
   logic               armed_q, armed_d;

   logic               mem_we;
   logic [23:0]        addr_nx, addr_sh;
   logic [7:0]         rd_cur, rd_nxt, rd_sh;
   logic [7:0]         cmd_full;

   function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
      logic [ADDR_W-1:0] r;
`ifdef PSRAM_RSP_PAGEWRAP_EN
      r       = idx;
      r[9:0]  = idx[9:0] + 10'd1;
`else
      r       = idx + ADDR_W'(1);
`endif
      return r;
   endfunction

   always_comb begin
      addr_nx                = addr_q;
      addr_nx[ADDR_W-1:0]    = next_idx(addr_q[ADDR_W-1:0]);
      addr_sh                = {addr_q[19:0], bus.SIO_i};
      cmd_full               = {cmd_hi_q, bus.SIO_i};
      rd_cur                 = mem_q[addr_q[ADDR_W-1:0]];
      rd_nxt                 = mem_q[addr_nx[ADDR_W-1:0]];
      rd_sh                  = mem_q[addr_sh[ADDR_W-1:0]];
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      cmd_hi_d  = cmd_hi_q;
      is_rd_d   = is_rd_q;
      lo_d      = lo_q;
      wbuf_d    = wbuf_q;
      sio_o_d   = sio_o_q;
      sio_oe_d  = sio_oe_q;
      cmd_err_d = 1'b0;
      armed_d   = armed_q;
      mem_we    = 1'b0;

      // Deselect aborts everything; a half-received write byte simply never commits.
      if (bus.CE_n) begin
         state_d  = IDLE;
         cnt_d    = '0;
         lo_d     = 1'b0;
         sio_o_d  = 4'h0;
         sio_oe_d = 1'b0;
         armed_d  = 1'b1;
      end else if (bus.SCLK_EN) begin
         case (state_q)
            IDLE: begin
               if (armed_q) begin
                  cmd_hi_d = bus.SIO_i;
                  state_d  = CMD;
               end
            end
            CMD: begin
               cnt_d = '0;
               if (cmd_full == CMD_QREAD || cmd_full == CMD_QWRITE) begin
                  is_rd_d = (cmd_full == CMD_QREAD);
                  state_d = ADDR;
               end else begin
                  cmd_err_d = 1'b1;
                  state_d   = IGNORE;
               end
            end
            ADDR: begin
               addr_d = addr_sh;
               if (cnt_q == CNT_W'(5)) begin
                  cnt_d = '0;
                  lo_d  = 1'b0;
                  if (!is_rd_q) begin
                     state_d = WDATA;
                  end else if (RD_WAIT == 0) begin
                     state_d  = RDATA;
                     sio_o_d  = rd_sh[7:4];
                     sio_oe_d = 1'b1;
                     lo_d     = 1'b1;
                  end else begin
                     state_d = WAIT;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT: begin
               // The first high nibble is registered on the last wait beat.
               if (cnt_q == CNT_W'(WAIT_LAST)) begin
                  cnt_d    = '0;
                  state_d  = RDATA;
                  sio_o_d  = rd_cur[7:4];
                  sio_oe_d = 1'b1;
                  lo_d     = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RDATA: begin
               if (lo_q) begin
                  sio_o_d = rd_cur[3:0];
                  lo_d    = 1'b0;
               end else begin
                  addr_d  = addr_nx;
                  sio_o_d = rd_nxt[7:4];
                  lo_d    = 1'b1;
               end
            end
            WDATA: begin
               if (!lo_q) begin
                  wbuf_d = bus.SIO_i;
                  lo_d   = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  addr_d = addr_nx;
                  lo_d   = 1'b0;
               end
            end
            IGNORE: ;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         cmd_hi_q  <= 4'h0;
         is_rd_q   <= 1'b0;
         lo_q      <= 1'b0;
         wbuf_q    <= 4'h0;
         sio_o_q   <= 4'h0;
         sio_oe_q  <= 1'b0;
         cmd_err_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         cmd_hi_q  <= cmd_hi_d;
         is_rd_q   <= is_rd_d;
         lo_q      <= lo_d;
         wbuf_q    <= wbuf_d;
         sio_o_q   <= sio_o_d;
         sio_oe_q  <= sio_oe_d;
         cmd_err_q <= cmd_err_d;
         armed_q   <= armed_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (mem_we) mem_q[addr_q[ADDR_W-1:0]] <= {wbuf_q, bus.SIO_i};
   end

   assign bus.SIO_o   = sio_o_q;
   assign bus.SIO_oe  = sio_oe_q;
   assign bus.CMD_ERR = cmd_err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: writes, reads, wrap, bad command,
// aborted write, stall hold and reset during a read burst.
module tb_psram_qpi_responder;

   localparam int ADDR_W  = 12;
   localparam int RD_WAIT = 6;

   logic HCLK;
   logic HRESETn;
   int   checks = 0;
   int   errors = 0;

   psram_qpi_responder_if bus ();

   psram_qpi_responder #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT)) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [3:0] n);
      @(negedge HCLK);
      bus.CE_n    = 1'b0;
      bus.SCLK_EN = 1'b1;
      bus.SIO_i   = n;
   endtask

   task automatic cs_high();
      @(negedge HCLK);
      bus.CE_n    = 1'b1;
      bus.SCLK_EN = 1'b0;
      bus.SIO_i   = 4'h0;
      @(negedge HCLK);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
      beat(cmd[7:4]);
      beat(cmd[3:0]);
      for (int i = 0; i < 6; i++) beat(a[23-4*i -: 4]);
   endtask

   // Writes n bytes (from data[31:24] down); half_last sends only the last byte's high nibble.
   task automatic wr(input string tag, input logic [23:0] a, input int n,
                     input logic [31:0] data, input bit half_last);
      send_hdr(8'h02, a);
      for (int i = 0; i < 2 * n; i++) begin
         if (!(half_last && i == 2 * n - 1)) begin
            beat(data[31-4*i -: 4]);
            check({tag, "_oe"}, {7'd0, bus.SIO_oe}, 8'h00);
         end
      end
      cs_high();
      check({tag, "_oe_end"}, {7'd0, bus.SIO_oe}, 8'h00);
   endtask

   // Reads n bytes and compares nibbles; stall idle cycles are inserted after the first data beat.
   task automatic rd(input string tag, input logic [23:0] a, input int n,
                     input logic [31:0] exp, input int stall);
      send_hdr(8'hEB, a);
      for (int i = 0; i < RD_WAIT; i++) begin
         beat(4'h0);
         check({tag, "_wait_oe"}, {7'd0, bus.SIO_oe}, 8'h00);
      end
      for (int i = 0; i < 2 * n; i++) begin
         if (i == 1) begin
            for (int s = 0; s < stall; s++) begin
               @(negedge HCLK);
               bus.SCLK_EN = 1'b0;
               check({tag, "_stall_o"}, {4'h0, bus.SIO_o}, {4'h0, exp[27:24]});
               check({tag, "_stall_oe"}, {7'd0, bus.SIO_oe}, 8'h01);
            end
         end
         beat(4'h0);
         check({tag, "_oe"}, {7'd0, bus.SIO_oe}, 8'h01);
         check({tag, "_o"}, {4'h0, bus.SIO_o}, {4'h0, exp[31-4*i -: 4]});
      end
      cs_high();
      check({tag, "_oe_end"}, {7'd0, bus.SIO_oe}, 8'h00);
   endtask

   initial begin
      HRESETn     = 1'b0;
      bus.CE_n    = 1'b1;
      bus.SCLK_EN = 1'b0;
      bus.SIO_i   = 4'h0;
      repeat (2) @(negedge HCLK);
      check("rst_oe", {7'd0, bus.SIO_oe}, 8'h00);
      check("rst_o", {4'h0, bus.SIO_o}, 8'h00);
      check("rst_err", {7'd0, bus.CMD_ERR}, 8'h00);
      HRESETn = 1'b1;
      repeat (2) @(negedge HCLK);

      // Basic write then read with a stall in the data phase
      wr("wr10", 24'h000010, 2, 32'hA53C_0000, 1'b0);
      rd("rd10", 24'h000010, 2, 32'hA53C_0000, 3);

      // Burst across 0x3FF: linear wrap lands at 0x400, page wrap at 0x000
      wr("wr000", 24'h000000, 1, 32'h5A00_0000, 1'b0);
      wr("wr3ff", 24'h0003FF, 2, 32'h1122_0000, 1'b0);
      rd("rd3ff", 24'h0003FF, 2, 32'h1122_0000, 0);
`ifdef PSRAM_RSP_PAGEWRAP_EN
      rd("rd000", 24'h000000, 1, 32'h2200_0000, 0);
`else
      rd("rd000", 24'h000000, 1, 32'h5A00_0000, 0);
      rd("rd400", 24'h000400, 1, 32'h2200_0000, 0);
`endif

      // Upper address bits beyond ADDR_W are ignored
      rd("rdhi", 24'hABC010, 1, 32'hA500_0000, 0);

      // Unsupported command 0x9F
      beat(4'h9);
      beat(4'hF);
      beat(4'h0);
      check("err_pulse", {7'd0, bus.CMD_ERR}, 8'h01);
      for (int i = 0; i < 10; i++) begin
         beat(4'h5);
         check("err_clear", {7'd0, bus.CMD_ERR}, 8'h00);
         check("ign_oe", {7'd0, bus.SIO_oe}, 8'h00);
      end
      cs_high();
      rd("rd_after_err", 24'h000010, 2, 32'hA53C_0000, 0);

      // Write aborted after the high nibble of byte 2
      wr("wr20", 24'h000020, 2, 32'h0099_0000, 1'b0);
      wr("wr_abort", 24'h000020, 2, 32'h7788_0000, 1'b1);
      rd("rd20", 24'h000020, 2, 32'h7799_0000, 0);

      // Reset pulsed during RDATA with CE_n still low
      send_hdr(8'hEB, 24'h000010);
      for (int i = 0; i < RD_WAIT + 1; i++) beat(4'h0);
      check("pre_rst_oe", {7'd0, bus.SIO_oe}, 8'h01);
      #1 HRESETn = 1'b0;
      #1;
      check("async_rst_oe", {7'd0, bus.SIO_oe}, 8'h00);
      check("async_rst_o", {4'h0, bus.SIO_o}, 8'h00);
      @(negedge HCLK);
      HRESETn = 1'b1;
      // CE_n never went high since reset: a full read header must be ignored
      send_hdr(8'hEB, 24'h000010);
      for (int i = 0; i < RD_WAIT + 4; i++) begin
         beat(4'h0);
         check("unarmed_oe", {7'd0, bus.SIO_oe}, 8'h00);
      end
      cs_high();
      rd("rd_post_rst", 24'h000010, 2, 32'hA53C_0000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
